// File: rtl/flash_read_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flash_read_seq_pkg
//  Description : Shared definitions for the flash read sequencer and the SPI
//                flash controller: register offsets, status bits, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package flash_read_seq_pkg;

  // Controller register offsets
  localparam logic [7:0] REG_CMD    = 8'h00;
  localparam logic [7:0] REG_ADDR   = 8'h04;
  localparam logic [7:0] REG_LEN    = 8'h08;
  localparam logic [7:0] REG_START  = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h10;
  localparam logic [7:0] REG_DATA   = 8'h14;

  // Status register bit indices
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  // Sequencer state encoding
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_CMD    = 4'd1,
    WR_ADDR   = 4'd2,
    WR_LEN    = 4'd3,
    WR_GO     = 4'd4,
    POLL_RD   = 4'd5,
    POLL_CHK  = 4'd6,
    DATA_RD   = 4'd7,
    DATA_CAP  = 4'd8,
    RESP      = 4'd9,
    WR_STOP   = 4'd10,
    DRAIN_RD  = 4'd11,
    DRAIN_CHK = 4'd12
  } state_t;

endpackage
`default_nettype wire

// File: rtl/flash_read_seq.sv
`default_nettype none
// ============================================================================
//  Module      : flash_read_seq
//  Description : Reads a run of flash bytes one controller transaction per
//                byte over a simple register bus, returning one response
//                beat per byte. Poll loops are bounded by POLL_LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_read_seq
  import flash_read_seq_pkg::*;
#(
  parameter logic [7:0] READ_CMD   = 8'h03,
  parameter int         POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_count,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        busy,
  output logic        wr_en,
  output logic        rd_en,
  output logic [7:0]  addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  localparam logic [15:0] c_POLL_LIMIT = 16'(POLL_LIMIT);

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_cur_addr;
  logic [15:0] r_remaining;
  logic [15:0] r_poll_cnt;
  logic [7:0]  r_rsp_data;
  logic        r_err;

  logic w_expired;
  logic w_done;
  logic w_ctl_idle;
  logic w_unused;

  assign w_expired  = (r_poll_cnt >= c_POLL_LIMIT);
  assign w_done     = rdata[STAT_DONE];
  assign w_ctl_idle = !rdata[STAT_DONE] && !rdata[STAT_BUSY];
  assign w_unused   = ^rdata[31:8];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and register-bus / handshake outputs
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    addr      = 8'd0;
    wdata     = 32'd0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = (req_count == 16'd0) ? RESP : WR_CMD;
      end
      WR_CMD: begin
        wr_en = 1'b1; addr = REG_CMD; wdata = {24'd0, READ_CMD};
        w_next = WR_ADDR;
      end
      WR_ADDR: begin
        wr_en = 1'b1; addr = REG_ADDR; wdata = {8'd0, r_cur_addr};
        w_next = WR_LEN;
      end
      WR_LEN: begin
        wr_en = 1'b1; addr = REG_LEN; wdata = 32'd1;
        w_next = WR_GO;
      end
      WR_GO: begin
        wr_en = 1'b1; addr = REG_START; wdata = 32'd1;
        w_next = POLL_RD;
      end
      POLL_RD: begin
        rd_en = 1'b1; addr = REG_STATUS;
        w_next = POLL_CHK;
      end
      POLL_CHK: begin
        // A done flag on the final permitted poll still counts as success
        if (w_done)         w_next = DATA_RD;
        else if (w_expired) w_next = WR_STOP;
        else                w_next = POLL_RD;
      end
      DATA_RD: begin
        rd_en = 1'b1; addr = REG_DATA;
        w_next = DATA_CAP;
      end
      DATA_CAP: w_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        // An error beat always terminates the request; stop was already written
        if (rsp_ready) w_next = r_err ? IDLE : WR_STOP;
      end
      WR_STOP: begin
        wr_en = 1'b1; addr = REG_START; wdata = 32'd0;
        w_next = DRAIN_RD;
      end
      DRAIN_RD: begin
        rd_en = 1'b1; addr = REG_STATUS;
        w_next = DRAIN_CHK;
      end
      DRAIN_CHK: begin
        if (w_ctl_idle) begin
          if (r_err)                     w_next = RESP;
          else if (r_remaining == 16'd1) w_next = IDLE;
          else                           w_next = WR_CMD;
        end else if (w_expired) begin
          w_next = RESP;
        end else begin
          w_next = DRAIN_RD;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Request context, poll counter, response data and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr  <= 24'd0;
      r_remaining <= 16'd0;
      r_poll_cnt  <= 16'd0;
      r_rsp_data  <= 8'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_cur_addr  <= req_addr;
            r_remaining <= req_count;
            r_err       <= (req_count == 16'd0);
            r_rsp_data  <= 8'd0;
          end
        end
        WR_GO, WR_STOP:    r_poll_cnt <= 16'd0;
        POLL_RD, DRAIN_RD: r_poll_cnt <= r_poll_cnt + 16'd1;
        POLL_CHK: begin
          if (!w_done && w_expired) begin
            r_err      <= 1'b1;
            r_rsp_data <= 8'd0;
          end
        end
        DATA_CAP: r_rsp_data <= rdata[7:0];
        DRAIN_CHK: begin
          if (w_ctl_idle) begin
            if (!r_err) begin
              r_remaining <= r_remaining - 16'd1;
              r_cur_addr  <= r_cur_addr + 24'd1;
            end
          end else if (w_expired) begin
            r_err      <= 1'b1;
            r_rsp_data <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign rsp_data = r_rsp_data;
  assign rsp_err  = rsp_valid && r_err;
  assign rsp_last = rsp_valid && (r_err || (r_remaining == 16'd1));

endmodule
`default_nettype wire
